// File: rtl/dxt_table_ctrl.sv
// Table access controller: round-robin hardware ports plus one CSR client
// sharing a fixed-latency single-port entry memory.
module dxt_table_ctrl #(
  parameter int unsigned EntryWords = 2,
  parameter int unsigned IdxW       = 7,
  parameter int unsigned NumHw      = 2,
  parameter int unsigned MemLat     = 1,
  parameter int unsigned SwWrEn     = 1,
  parameter int unsigned StarveLim  = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumHw-1:0]                    hw_req_i,
  input  logic [NumHw-1:0]                    hw_we_i,
  input  logic [NumHw*IdxW-1:0]               hw_idx_i,
  input  logic [NumHw*32*EntryWords-1:0]      hw_wdata_i,
  output logic [NumHw-1:0]                    hw_gnt_o,
  output logic [NumHw-1:0]                    hw_rvalid_o,
  output logic [32*EntryWords-1:0]            hw_rdata_o,
  input  logic                                sw_req_i,
  input  logic                                sw_req_is_wr_i,
  input  logic [IdxW+$clog2(EntryWords)+1:0]  sw_addr_i,
  input  logic [31:0]                         sw_wr_data_i,
  output logic [31:0]                         sw_rd_data_o,
  output logic                                sw_rd_ack_o,
  output logic                                sw_wr_ack_o,
  output logic                                sw_wr_err_o,
  output logic                                mem_req_o,
  output logic                                mem_write_o,
  output logic [IdxW-1:0]                     mem_addr_o,
  output logic [32*EntryWords-1:0]            mem_wdata_o,
  output logic [32*EntryWords-1:0]            mem_wmask_o,
  input  logic                                mem_rvalid_i,
  input  logic [32*EntryWords-1:0]            mem_rdata_i
);

  localparam int unsigned W    = 32 * EntryWords;
  localparam int unsigned WdW  = $clog2(EntryWords);
  localparam int unsigned SA   = IdxW + WdW + 2;
  localparam int unsigned PtrW = (NumHw > 1) ? $clog2(NumHw) : 1;
  localparam int unsigned StW  = (StarveLim > 0) ? $clog2(StarveLim + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } sw_state_e;

  sw_state_e          state_q, state_d;
  logic [SA-1:2]      sw_waddr_q;
  logic [31:0]        sw_wdata_q;
  logic               sw_wr_q;
  logic [IdxW-1:0]    sw_idx;
  logic [WdW-1:0]     sw_word;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [StW-1:0]     starve_q, starve_d;
  logic [PtrW-1:0]    cand, gnt_port;
  logic               hw_hit, sw_bid, sw_gnt;
  logic               drop_wr;
  logic [MemLat-1:0]  trk_vld_q, trk_sw_q;
  logic [PtrW-1:0]    trk_port_q [MemLat];
  logic               ret_vld, ret_sw;
  logic [PtrW-1:0]    ret_port;
  logic [IdxW-1:0]    hw_idx   [NumHw];
  logic [W-1:0]       hw_wdata [NumHw];
  logic               unused_addr;

  assign unused_addr = ^sw_addr_i[1:0];

  // Unpack the flattened per-port buses
  for (genvar n = 0; n < NumHw; n++) begin : g_unpack
    assign hw_idx[n]   = hw_idx_i[n*IdxW +: IdxW];
    assign hw_wdata[n] = hw_wdata_i[n*W +: W];
  end

  assign sw_idx   = sw_waddr_q[SA-1:WdW+2];
  assign sw_word  = sw_waddr_q[WdW+1:2];
  assign drop_wr  = (SwWrEn == 0) && sw_req_i && sw_req_is_wr_i && (state_q == IDLE);
  assign ret_vld  = trk_vld_q[MemLat-1];
  assign ret_sw   = trk_sw_q[MemLat-1];
  assign ret_port = trk_port_q[MemLat-1];

  // Arbitration, memory request and software FSM next state
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    starve_d    = '0;
    hw_gnt_o    = '0;
    sw_gnt      = 1'b0;
    hw_hit      = 1'b0;
    cand        = '0;
    gnt_port    = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    sw_bid      = (state_q == PEND) && ((SwWrEn != 0) || !sw_wr_q);

    for (int i = 0; i < int'(NumHw); i++) begin
      cand = PtrW'((int'(rr_ptr_q) + i) % int'(NumHw));
      if (!hw_hit && hw_req_i[cand]) begin
        hw_hit   = 1'b1;
        gnt_port = cand;
      end
    end

    if (rst_ni) begin
      if (sw_bid && (!hw_hit || (starve_q >= StW'(StarveLim)))) begin
        sw_gnt      = 1'b1;
        mem_req_o   = 1'b1;
        mem_write_o = sw_wr_q;
        mem_addr_o  = sw_idx;
        if (sw_wr_q) begin
          mem_wdata_o = W'(sw_wdata_q) << {sw_word, 5'd0};
          mem_wmask_o = W'(32'hFFFF_FFFF) << {sw_word, 5'd0};
        end
      end else if (hw_hit) begin
        hw_gnt_o[gnt_port] = 1'b1;
        mem_req_o          = 1'b1;
        mem_write_o        = hw_we_i[gnt_port];
        mem_addr_o         = hw_idx[gnt_port];
        if (hw_we_i[gnt_port]) begin
          mem_wdata_o = hw_wdata[gnt_port];
          mem_wmask_o = '1;
        end
        rr_ptr_d = (gnt_port == PtrW'(NumHw - 1)) ? '0 : gnt_port + PtrW'(1);
      end
    end

    if (sw_bid && !sw_gnt) begin
      starve_d = (starve_q >= StW'(StarveLim)) ? starve_q : starve_q + StW'(1);
    end

    unique case (state_q)
      IDLE:    if (sw_req_i) state_d = PEND;
      PEND: begin
        if ((SwWrEn == 0) && sw_wr_q) state_d = ACK;
        else if (sw_gnt)              state_d = sw_wr_q ? ACK : RDWAIT;
      end
      RDWAIT:  if (ret_vld && ret_sw) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, starvation counter and latched CSR request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      starve_q   <= '0;
      sw_waddr_q <= '0;
      sw_wdata_q <= '0;
      sw_wr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      if ((state_q == IDLE) && sw_req_i) begin
        sw_waddr_q <= sw_addr_i[SA-1:2];
        sw_wdata_q <= sw_wr_data_i;
        sw_wr_q    <= sw_req_is_wr_i;
      end
    end
  end

  // Read-source tracker: one stage per cycle of memory latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_vld_q <= '0;
      trk_sw_q  <= '0;
      for (int i = 0; i < int'(MemLat); i++) trk_port_q[i] <= '0;
    end else begin
      trk_vld_q[0]  <= (sw_gnt && !sw_wr_q) || ((|hw_gnt_o) && !hw_we_i[gnt_port]);
      trk_sw_q[0]   <= sw_gnt;
      trk_port_q[0] <= gnt_port;
      for (int i = int'(MemLat) - 1; i > 0; i--) begin
        trk_vld_q[i]  <= trk_vld_q[i-1];
        trk_sw_q[i]   <= trk_sw_q[i-1];
        trk_port_q[i] <= trk_port_q[i-1];
      end
    end
  end

  // Hardware read return is passed straight through to the owning port
  always_comb begin
    hw_rvalid_o = '0;
    if (ret_vld && !ret_sw && mem_rvalid_i) hw_rvalid_o[ret_port] = 1'b1;
  end

  assign hw_rdata_o = rst_ni ? mem_rdata_i : '0;

  // CSR responses; dropped read-only writes are acknowledged on acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_rd_ack_o  <= 1'b0;
      sw_rd_data_o <= '0;
      sw_wr_ack_o  <= 1'b0;
      sw_wr_err_o  <= 1'b0;
    end else begin
      sw_rd_ack_o  <= ret_vld && ret_sw && mem_rvalid_i;
      sw_rd_data_o <= (ret_vld && ret_sw && mem_rvalid_i) ?
                      mem_rdata_i[{sw_word, 5'd0} +: 32] : 32'd0;
      sw_wr_ack_o  <= ((state_q == ACK) && sw_wr_q && (SwWrEn != 0)) || drop_wr;
      sw_wr_err_o  <= drop_wr;
    end
  end

endmodule
